// File: rtl/shared_sbox_layer_serial.sv
// Two-share uBlock S-box layer: PAR shared lanes walk the state in NUM_NIBBLES/PAR beats
// and the full substituted state is published atomically with a one-cycle valid pulse.

module shared_sbox #(
   parameter int LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] x0,
   input  logic [3:0] x1,
   input  logic [3:0] g,
   output logic [3:0] y0,
   output logic [3:0] y1
);
   localparam int DLY = (LAT > 1) ? LAT - 1 : 1;

   logic [3:0] y0_d, y1_d;
   logic [3:0] y0_q [DLY];
   logic [3:0] y1_q [DLY];

   function automatic logic [3:0] ublock_sbox(input logic [3:0] x);
      logic [3:0] s;
      case (x)
         4'h0: s = 4'h7;  4'h1: s = 4'h4;  4'h2: s = 4'h9;  4'h3: s = 4'hC;
         4'h4: s = 4'hB;  4'h5: s = 4'hA;  4'h6: s = 4'hD;  4'h7: s = 4'h8;
         4'h8: s = 4'hF;  4'h9: s = 4'hE;  4'hA: s = 4'h1;  4'hB: s = 4'h6;
         4'hC: s = 4'h0;  4'hD: s = 4'h3;  4'hE: s = 4'h2;  default: s = 4'h5;
      endcase
      return s;
   endfunction

   // Share 1 is re-randomised by the guard nibble; share 0 absorbs the correction.
   always_comb begin
      y1_d = x1 ^ g;
      y0_d = ublock_sbox(x0 ^ x1) ^ y1_d;
   end

   // The layer's capture register is the final stage, so the lane holds LAT-1 stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < DLY; s++) begin
            y0_q[s] <= '0;
            y1_q[s] <= '0;
         end
      end else begin
         y0_q[0] <= y0_d;
         y1_q[0] <= y1_d;
         for (int s = 1; s < DLY; s++) begin
            y0_q[s] <= y0_q[s-1];
            y1_q[s] <= y1_q[s-1];
         end
      end
   end

   assign y0 = (LAT == 1) ? y0_d : y0_q[DLY-1];
   assign y1 = (LAT == 1) ? y1_d : y1_q[DLY-1];
endmodule

module shared_sbox_layer_serial #(
   parameter int NUM_NIBBLES = 16,
   parameter int PAR         = 4,
   parameter int SBOX_LAT    = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [4*NUM_NIBBLES-1:0] in_share0,
   input  logic [4*NUM_NIBBLES-1:0] in_share1,
   output logic                     busy,
   output logic                     out_valid,
   output logic [4*NUM_NIBBLES-1:0] out_share0,
   output logic [4*NUM_NIBBLES-1:0] out_share1
);
   localparam int W   = 4 * NUM_NIBBLES;
   localparam int B   = NUM_NIBBLES / PAR;
   localparam int BW  = (B > 1) ? $clog2(B) : 1;
   localparam int DW  = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
   localparam int DLY = (SBOX_LAT > 1) ? SBOX_LAT - 1 : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FEED  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          busy_q, busy_d;
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out0_q, out0_d, out1_q, out1_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [DW-1:0] drain_q, drain_d;
   logic [W-1:0]  work0_q, work0_d, work1_q, work1_d;
   logic [W-1:0]  snap_q, snap_d;
   logic [W-1:0]  cap0_q, cap0_d, cap1_q, cap1_d;
   logic          vld_q [DLY];
   logic          feed_vld, cap_en;

   logic [3:0]       lx0 [PAR];
   logic [3:0]       lx1 [PAR];
   logic [3:0]       lg  [PAR];
   logic [3:0]       ly0 [PAR];
   logic [3:0]       ly1 [PAR];
   logic [4*PAR-1:0] lane0_bits, lane1_bits;

   // Guards always come from the snapshot, never from the shifting work registers.
   always_comb begin
      int gidx;
      for (int i = 0; i < PAR; i++) begin
         lx0[i] = work0_q[W-1-4*i -: 4];
         lx1[i] = work1_q[W-1-4*i -: 4];
         gidx   = (int'(beat_q) * PAR + i + 1) % NUM_NIBBLES;
         lg[i]  = snap_q[W-1-4*gidx -: 4];
      end
   end

   for (genvar gi = 0; gi < PAR; gi++) begin : g_lane
      shared_sbox #(.LAT(SBOX_LAT)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .x0    (lx0[gi]),
         .x1    (lx1[gi]),
         .g     (lg[gi]),
         .y0    (ly0[gi]),
         .y1    (ly1[gi])
      );
   end

   always_comb begin
      lane0_bits = '0;
      lane1_bits = '0;
      for (int i = 0; i < PAR; i++) begin
         lane0_bits[4*PAR-1-4*i -: 4] = ly0[i];
         lane1_bits[4*PAR-1-4*i -: 4] = ly1[i];
      end
   end

   assign feed_vld = (state_q == ST_FEED);
   assign cap_en   = (SBOX_LAT == 1) ? feed_vld : vld_q[DLY-1];

   // Earliest beat ends up in the top nibbles after the final shift.
   always_comb begin
      cap0_d = cap0_q;
      cap1_d = cap1_q;
      if (cap_en) begin
         cap0_d = (cap0_q << (4*PAR)) | W'(lane0_bits);
         cap1_d = (cap1_q << (4*PAR)) | W'(lane1_bits);
      end
   end

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      out_valid_d = 1'b0;
      out0_d      = out0_q;
      out1_d      = out1_q;
      beat_d      = beat_q;
      drain_d     = drain_q;
      work0_d     = work0_q;
      work1_d     = work1_q;
      snap_d      = snap_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               work0_d = in_share0;
               work1_d = in_share1;
               snap_d  = in_share0;
               beat_d  = '0;
               busy_d  = 1'b1;
               state_d = ST_FEED;
            end
         end
         ST_FEED: begin
            work0_d = work0_q << (4*PAR);
            work1_d = work1_q << (4*PAR);
            if (beat_q == BW'(B-1)) begin
               beat_d  = '0;
               drain_d = '0;
               state_d = ST_DRAIN;
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end
         ST_DRAIN: begin
            if (drain_q == DW'(SBOX_LAT-1)) begin
               out0_d      = cap0_q;
               out1_d      = cap1_q;
               out_valid_d = 1'b1;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out0_q      <= '0;
         out1_q      <= '0;
         beat_q      <= '0;
         drain_q     <= '0;
         work0_q     <= '0;
         work1_q     <= '0;
         snap_q      <= '0;
         cap0_q      <= '0;
         cap1_q      <= '0;
         for (int s = 0; s < DLY; s++) vld_q[s] <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         out0_q      <= out0_d;
         out1_q      <= out1_d;
         beat_q      <= beat_d;
         drain_q     <= drain_d;
         work0_q     <= work0_d;
         work1_q     <= work1_d;
         snap_q      <= snap_d;
         cap0_q      <= cap0_d;
         cap1_q      <= cap1_d;
         vld_q[0]    <= feed_vld;
         for (int s = 1; s < DLY; s++) vld_q[s] <= vld_q[s-1];
      end
   end

   assign busy       = busy_q;
   assign out_valid  = out_valid_q;
   assign out_share0 = out0_q;
   assign out_share1 = out1_q;
endmodule
